// File: rtl/gs_butterfly_pkg.sv
// Shared types, constants and modular helpers for the Gentleman-Sande butterfly.
// Optional feature macro used by this slice: GS_INV_HALF_EN (halves results mod Q).
package blu_pkg;

   localparam int COEF_W = 32;
   localparam int Q      = 8380417;
   localparam int K      = $clog2(Q);
   localparam logic [63:0] MU = (64'd1 << (2 * K)) / 64'(Q);

   typedef logic [COEF_W-1:0] coef_t;
   typedef coef_t [1:0] lanes_t;
   typedef logic [2*COEF_W-1:0] prod_t;

   typedef struct packed {
      logic   v;
      lanes_t s;
      lanes_t d;
      coef_t  z;
   } s1_t;

   typedef struct packed {
      logic          v;
      lanes_t        s;
      prod_t [1:0]   p;
      coef_t         z;
   } s2_t;

   typedef struct packed {
      logic   v;
      lanes_t s;
      coef_t  z;
   } s3_t;

   function automatic coef_t mod_add(coef_t a, coef_t b, coef_t q);
      logic [COEF_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, q}) s = s - {1'b0, q};
      return s[COEF_W-1:0];
   endfunction

   // A borrow shows up in the extra top bit; one add of q restores range.
   function automatic coef_t mod_sub(coef_t a, coef_t b, coef_t q);
      logic [COEF_W:0] d;
      d = {1'b0, a} - {1'b0, b};
      if (d[COEF_W]) d = d + {1'b0, q};
      return d[COEF_W-1:0];
   endfunction

   function automatic coef_t half_mod(coef_t x, coef_t q);
      logic [COEF_W:0] h;
      if (x[0]) h = ({1'b0, x} + {1'b0, q}) >> 1;
      else h = {1'b0, x} >> 1;
      return h[COEF_W-1:0];
   endfunction

endpackage

// File: rtl/gs_butterfly_barrett_reduce.sv
// Two-stage Barrett reduction of one lane product (estimate, then final correction).
// With GS_INV_HALF_EN the corrected value is also multiplied by 2^-1 mod MOD.
module barrett_reduce
   import blu_pkg::*;
#(
   parameter int MOD = Q
) (
   input  logic  clk_i,
   input  logic  reset_ni,
   input  logic  en_i,
   input  prod_t p_i,
   output coef_t r_o
);

   localparam int PW = 2 * COEF_W;
   localparam int KB = $clog2(MOD);
   localparam logic [PW-1:0] MU_W = (PW'(1) << (2 * KB)) / PW'(MOD);
   localparam logic [PW-1:0] Q_W = PW'(MOD);
   localparam logic [COEF_W:0] Q_T = (COEF_W+1)'(MOD);
   localparam coef_t Q_C = coef_t'(MOD);

   logic [COEF_W:0] t_d, t_q;
   coef_t r_d, r_q;

   // Estimate lands below 3*MOD, so COEF_W+1 bits hold it.
   always_comb begin
      logic [PW-1:0] hi;
      logic [PW-1:0] est;
      hi  = p_i >> (KB - 1);
      est = PW'(({{PW{1'b0}}, hi} * {{PW{1'b0}}, MU_W}) >> (KB + 1));
      t_d = (COEF_W+1)'(p_i - est * Q_W);
   end

   always_comb begin
      logic [COEF_W:0] r;
      r = t_q;
      if (r >= Q_T) r = r - Q_T;
      if (r >= Q_T) r = r - Q_T;
`ifdef GS_INV_HALF_EN
      r_d = half_mod(coef_t'(r), Q_C);
`else
      r_d = coef_t'(r);
`endif
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         t_q <= '0;
         r_q <= '0;
      end else if (en_i) begin
         t_q <= t_d;
         r_q <= r_d;
      end
   end

   assign r_o = r_q;

endmodule

// File: rtl/gs_butterfly.sv
// Inverse-NTT Gentleman-Sande butterfly, two lanes, 4-stage stallable pipeline.
// Macro GS_INV_HALF_EN folds a 2^-1 mod Q scaling into the last stage.
module gs_butterfly #(
   parameter int DATA_WIDTH = 64,
   parameter int Q          = 8380417,
   parameter int LATENCY    = 4
) (
   input  logic                    clk_i,
   input  logic                    reset_ni,
   input  logic                    valid_i,
   output logic                    ready_o,
   input  logic [DATA_WIDTH-1:0]   data1_i,
   input  logic [DATA_WIDTH-1:0]   data2_i,
   input  logic [DATA_WIDTH/2-1:0] zeta_i,
   output logic                    valid_o,
   input  logic                    ready_i,
   output logic [DATA_WIDTH-1:0]   data1_o,
   output logic [DATA_WIDTH-1:0]   data2_o,
   output logic [DATA_WIDTH/2-1:0] zeta_o
);
   import blu_pkg::*;

   localparam coef_t QC = coef_t'(Q);

   if (LATENCY != 4) begin : g_bad_latency
      $error("gs_butterfly: LATENCY must be 4");
   end
   if (DATA_WIDTH != 2 * COEF_W) begin : g_bad_width
      $error("gs_butterfly: DATA_WIDTH must be 2*COEF_W");
   end
   if (longint'(Q) >= (64'd1 << (COEF_W - 1))) begin : g_bad_q
      $error("gs_butterfly: Q too large for COEF_W");
   end

   logic   en;
   lanes_t a, b, r;
   s1_t    s1_d, s1_q;
   s2_t    s2_d, s2_q;
   s3_t    s3_d, s3_q;
   s3_t    s4_d, s4_q;

   // One global enable: the whole pipe advances or the whole pipe holds.
   assign en      = ready_i | ~s4_q.v;
   assign ready_o = en;
   assign a       = data1_i;
   assign b       = data2_i;

   always_comb begin
      s1_d   = '0;
      s1_d.v = valid_i;
      s1_d.z = zeta_i;
      for (int i = 0; i < 2; i++) begin
         s1_d.s[i] = mod_add(a[i], b[i], QC);
         s1_d.d[i] = mod_sub(a[i], b[i], QC);
      end
   end

   always_comb begin
      s2_d   = '0;
      s2_d.v = s1_q.v;
      s2_d.s = s1_q.s;
      s2_d.z = s1_q.z;
      for (int i = 0; i < 2; i++) begin
         s2_d.p[i] = {{COEF_W{1'b0}}, s1_q.d[i]}
                   * {{COEF_W{1'b0}}, s1_q.z};
      end
   end

   always_comb begin
      s3_d   = '0;
      s3_d.v = s2_q.v;
      s3_d.s = s2_q.s;
      s3_d.z = s2_q.z;
   end

   always_comb begin
      s4_d   = '0;
      s4_d.v = s3_q.v;
      s4_d.z = s3_q.z;
      for (int i = 0; i < 2; i++) begin
`ifdef GS_INV_HALF_EN
         s4_d.s[i] = half_mod(s3_q.s[i], QC);
`else
         s4_d.s[i] = s3_q.s[i];
`endif
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
         s4_q <= '0;
      end else if (en) begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
         s4_q <= s4_d;
      end
   end

   for (genvar i = 0; i < 2; i++) begin : g_lane
      barrett_reduce #(
         .MOD(Q)
      ) u_barrett (
         .clk_i   (clk_i),
         .reset_ni(reset_ni),
         .en_i    (en),
         .p_i     (s2_q.p[i]),
         .r_o     (r[i])
      );
   end

   assign valid_o = s4_q.v;
   assign data1_o = s4_q.s;
   assign data2_o = r;
   assign zeta_o  = s4_q.z;

endmodule

// File: tb/tb_gs_butterfly.sv
// Self-checking bench for gs_butterfly: directed vectors, stalled stream, reset.
module tb_gs_butterfly;

   localparam longint QM = 8380417;

   logic        clk = 1'b0;
   logic        reset_ni = 1'b0;
   logic        valid_i = 1'b0;
   logic        ready_i = 1'b1;
   logic [63:0] data1_i = '0;
   logic [63:0] data2_i = '0;
   logic [31:0] zeta_i = '0;
   logic        ready_o, valid_o;
   logic [63:0] data1_o, data2_o;
   logic [31:0] zeta_o;

   int n_tests = 0;
   int n_fail = 0;

   gs_butterfly #(
      .DATA_WIDTH(64),
      .Q(8380417),
      .LATENCY(4)
   ) dut (
      .clk_i   (clk),
      .reset_ni(reset_ni),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .data1_i (data1_i),
      .data2_i (data2_i),
      .zeta_i  (zeta_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .data1_o (data1_o),
      .data2_o (data2_o),
      .zeta_o  (zeta_o)
   );

   always #5 clk = ~clk;

   function automatic longint scale(longint x);
`ifdef GS_INV_HALF_EN
      return (x * ((QM + 1) / 2)) % QM;
`else
      return x;
`endif
   endfunction

   function automatic logic [31:0] ref_sum(longint a, longint b);
      return 32'(scale((a + b) % QM));
   endfunction

   function automatic logic [31:0] ref_dif(longint a, longint b, longint z);
      return 32'(scale((((a - b + QM) % QM) * z) % QM));
   endfunction

   task automatic test_reset();
      reset_ni = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++;
      if (valid_o !== 1'b0 || data1_o !== 64'd0 || data2_o !== 64'd0 || zeta_o !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b d1=%h d2=%h z=%h, want all 0", valid_o, data1_o, data2_o, zeta_o);
      end
      reset_ni = 1'b1;
      #1;
      n_tests++;
      if (ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: got %b want 1", ready_o);
      end
   endtask

   task automatic test_vector(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] z, input logic [31:0] e1, input logic [31:0] e2);
      int lat;
      @(negedge clk);
      ready_i = 1'b1;
      valid_i = 1'b1;
      data1_i = {a, a};
      data2_i = {b, b};
      zeta_i  = z;
      #1;
      n_tests++;
      if (ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_ready: got %b want 1", name, ready_o);
      end
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      lat = 1;
      while (valid_o !== 1'b1 && lat < 12) begin
         @(posedge clk);
         #1;
         lat++;
      end
      n_tests++;
      if (lat != 4) begin
         n_fail++;
         $display("FAIL %s_latency: got %0d want 4", name, lat);
      end
      n_tests++;
      if (data1_o !== {e1, e1} || data2_o !== {e2, e2} || zeta_o !== z) begin
         n_fail++;
         $display("FAIL %s_data: got d1=%h d2=%h z=%h want d1=%h d2=%h z=%h",
                  name, data1_o, data2_o, zeta_o, {e1, e1}, {e2, e2}, z);
      end
      @(posedge clk);
      #1;
      n_tests++;
      if (valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_single: valid_o got %b want 0", name, valid_o);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] q1[$];
      logic [63:0] q2[$];
      logic [31:0] qz[$];
      logic [31:0] ba[16][2];
      logic [31:0] bb[16][2];
      logic [31:0] bz[16];
      logic [63:0] h1, h2;
      logic [31:0] hz;
      logic        held;
      int sent, recv, cyc, bad_stall, bad_ready, bad_data;
      for (int i = 0; i < 16; i++) begin
         for (int l = 0; l < 2; l++) begin
            ba[i][l] = $urandom_range(8380416);
            bb[i][l] = $urandom_range(8380416);
         end
         bz[i] = $urandom_range(8380416);
      end
      sent = 0; recv = 0; cyc = 0; held = 1'b0;
      bad_stall = 0; bad_ready = 0; bad_data = 0;
      h1 = '0; h2 = '0; hz = '0;
      while ((sent < 16 || recv < 16) && cyc < 200) begin
         @(negedge clk);
         ready_i = !(cyc inside {3, 4, 5, 9});
         valid_i = (sent < 16);
         if (sent < 16) begin
            data1_i = {ba[sent][1], ba[sent][0]};
            data2_i = {bb[sent][1], bb[sent][0]};
            zeta_i  = bz[sent];
         end
         #1;
         if (valid_o && !ready_i && ready_o !== 1'b0) bad_ready++;
         if (held && (valid_o !== 1'b1 || data1_o !== h1 || data2_o !== h2 || zeta_o !== hz))
            bad_stall++;
         if (valid_o === 1'b1 && ready_i) begin
            if (q1.size() == 0) bad_data++;
            else begin
               if (data1_o !== q1[0] || data2_o !== q2[0] || zeta_o !== qz[0]) begin
                  bad_data++;
                  $display("FAIL stream_beat%0d: got d1=%h d2=%h z=%h want d1=%h d2=%h z=%h",
                           recv, data1_o, data2_o, zeta_o, q1[0], q2[0], qz[0]);
               end
               void'(q1.pop_front());
               void'(q2.pop_front());
               void'(qz.pop_front());
            end
            recv++;
         end
         if (valid_i && ready_o === 1'b1) begin
            q1.push_back({ref_sum(ba[sent][1], bb[sent][1]), ref_sum(ba[sent][0], bb[sent][0])});
            q2.push_back({ref_dif(ba[sent][1], bb[sent][1], bz[sent]),
                          ref_dif(ba[sent][0], bb[sent][0], bz[sent])});
            qz.push_back(bz[sent]);
            sent++;
         end
         held = valid_o && !ready_i;
         h1 = data1_o; h2 = data2_o; hz = zeta_o;
         cyc++;
      end
      valid_i = 1'b0;
      ready_i = 1'b1;
      n_tests++;
      if (recv != 16 || sent != 16) begin
         n_fail++;
         $display("FAIL stream_count: got sent=%0d recv=%0d want 16/16", sent, recv);
      end
      n_tests++;
      if (bad_data != 0) begin
         n_fail++;
         $display("FAIL stream_data: got %0d bad beats want 0", bad_data);
      end
      n_tests++;
      if (bad_stall != 0) begin
         n_fail++;
         $display("FAIL stream_stall_stable: got %0d changes want 0", bad_stall);
      end
      n_tests++;
      if (bad_ready != 0) begin
         n_fail++;
         $display("FAIL stream_ready_low: got %0d violations want 0", bad_ready);
      end
   endtask

   task automatic test_reset_flight();
      int w, stale;
      ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         valid_i = 1'b1;
         data1_i = {32'd100 + 32'(i), 32'd200 + 32'(i)};
         data2_i = {32'd7, 32'd9};
         zeta_i  = 32'd12345;
      end
      @(negedge clk);
      valid_i = 1'b0;
      w = 0;
      while (valid_o !== 1'b1 && w < 10) begin
         @(negedge clk);
         w++;
      end
      n_tests++;
      if (valid_o !== 1'b1) begin
         n_fail++;
         $display("FAIL flight_valid: got %b want 1", valid_o);
      end
      reset_ni = 1'b0;
      #1;
      n_tests++;
      if (valid_o !== 1'b0 || data1_o !== 64'd0 || data2_o !== 64'd0 || zeta_o !== 32'd0) begin
         n_fail++;
         $display("FAIL flight_reset: got v=%b d1=%h d2=%h z=%h want all 0", valid_o, data1_o, data2_o, zeta_o);
      end
      @(negedge clk);
      reset_ni = 1'b1;
      stale = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (valid_o !== 1'b0) stale++;
      end
      n_tests++;
      if (stale != 0) begin
         n_fail++;
         $display("FAIL flight_stale: got %0d valid cycles want 0", stale);
      end
   endtask

   task automatic test_out_of_range();
      int lat;
      @(negedge clk);
      ready_i = 1'b1;
      valid_i = 1'b1;
      data1_i = '1;
      data2_i = {32'd0, 32'hFFFF_FFF0};
      zeta_i  = '1;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      lat = 1;
      while (valid_o !== 1'b1 && lat < 12) begin
         @(posedge clk);
         #1;
         lat++;
      end
      n_tests++;
      if (lat != 4 || $isunknown({data1_o, data2_o, zeta_o})) begin
         n_fail++;
         $display("FAIL oor_output: got lat=%0d d1=%h d2=%h want lat=4 and no X", lat, data1_o, data2_o);
      end
   endtask

   initial begin
      test_reset();
`ifdef GS_INV_HALF_EN
      test_vector("basic", 32'd5, 32'd3, 32'd2, 32'd4, 32'd2);
      test_vector("neg_diff", 32'd3, 32'd5, 32'd1, 32'd4, 32'd8380416);
      test_vector("max_eq", 32'd8380416, 32'd8380416, 32'd7, 32'd8380416, 32'd0);
      test_vector("max_zeta", 32'd8380416, 32'd0, 32'd8380416, 32'd4190208, 32'd4190209);
`else
      test_vector("basic", 32'd5, 32'd3, 32'd2, 32'd8, 32'd4);
      test_vector("neg_diff", 32'd3, 32'd5, 32'd1, 32'd8, 32'd8380415);
      test_vector("max_eq", 32'd8380416, 32'd8380416, 32'd7, 32'd8380415, 32'd0);
      test_vector("max_zeta", 32'd8380416, 32'd0, 32'd8380416, 32'd8380416, 32'd1);
`endif
      test_back_to_back();
      test_reset_flight();
      test_out_of_range();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
